// File: rtl/booth2_seq_mult_pkg.sv
// rtl/booth2_seq_mult_pkg.sv - shared widths, FSM states and Booth digit codes
package booth2_seq_mult_pkg;

    localparam int A_W    = 16;
    localparam int B_W    = 16;
    localparam int P_W    = 32;
    localparam int DIGITS = 8;
    localparam int CNT_W  = $clog2(DIGITS);
    localparam int PP_W   = A_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Radix-4 Booth digit codes {b[2i+1], b[2i], b[2i-1]}
    localparam logic [2:0] DIG_ZERO_0 = 3'b000;
    localparam logic [2:0] DIG_P1A_0  = 3'b001;
    localparam logic [2:0] DIG_P1A_1  = 3'b010;
    localparam logic [2:0] DIG_P2A    = 3'b011;
    localparam logic [2:0] DIG_M2A    = 3'b100;
    localparam logic [2:0] DIG_M1A_0  = 3'b101;
    localparam logic [2:0] DIG_M1A_1  = 3'b110;
    localparam logic [2:0] DIG_ZERO_1 = 3'b111;

endpackage

// File: rtl/booth2_pp_decoder.sv
// rtl/booth2_pp_decoder.sv - radix-4 Booth partial-product decoder, sign bit delivered inverted
module booth2_pp_decoder
    import booth2_seq_mult_pkg::*;
(
    input  logic [A_W-1:0]  a,
    input  logic [2:0]      digit,
    output logic [PP_W-1:0] pp_n
);

    logic [A_W:0]    a_sx;
    logic [A_W:0]    a_neg;
    logic [PP_W-1:0] pp;

    // Negating in 17 bits keeps -(-32768) representable as +32768
    assign a_sx  = {a[A_W-1], a};
    assign a_neg = ~a_sx + {{A_W{1'b0}}, 1'b1};

    always_comb begin
        pp = '0;
        case (digit)
            DIG_ZERO_0, DIG_ZERO_1: pp = '0;
            DIG_P1A_0, DIG_P1A_1:   pp = {a_sx[A_W], a_sx};
            DIG_P2A:                pp = {a_sx, 1'b0};
            DIG_M2A:                pp = {a_neg, 1'b0};
            DIG_M1A_0, DIG_M1A_1:   pp = {a_neg[A_W], a_neg};
            default:                pp = '0;
        endcase
    end

    assign pp_n = {~pp[PP_W-1], pp[PP_W-2:0]};

endmodule

// File: rtl/booth2_seq_mult.sv
// rtl/booth2_seq_mult.sv - sequential radix-4 Booth 16x16 signed multiplier, one digit per cycle
module booth2_seq_mult
    import booth2_seq_mult_pkg::*;
(
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] a_in,
    input  logic [B_W-1:0] b_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] p_out,
    output logic           busy
);

    state_t          state;
    logic [A_W-1:0]  a_reg;
    logic [B_W:0]    b_reg;
    logic [P_W-1:0]  acc;
    logic [CNT_W-1:0] cnt;

    logic [2:0]      digit;
    logic [PP_W-1:0] pp_raw;
    logic [PP_W-1:0] pp;
    logic [P_W-1:0]  pp_ext;
    logic [P_W-1:0]  pp_shifted;
    logic [P_W-1:0]  sum;

    // b_reg[0] is the implicit b[-1]=0, so digit i sits at bits 2i+2..2i
    assign digit = b_reg[{cnt, 1'b0} +: 3];

    booth2_pp_decoder u_dec (
        .a     (a_reg),
        .digit (digit),
        .pp_n  (pp_raw)
    );

    assign pp         = {~pp_raw[PP_W-1], pp_raw[PP_W-2:0]};
    assign pp_ext     = {{(P_W-PP_W){pp[PP_W-1]}}, pp};
    assign pp_shifted = pp_ext << {cnt, 1'b0};
    assign sum        = acc + pp_shifted;

    // in_ready only rises on a clock edge, so reset release is taken synchronously
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            p_out     <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    out_valid <= 1'b0;
                    p_out     <= '0;
                    if (in_valid && in_ready) begin
                        a_reg    <= a_in;
                        b_reg    <= {b_in, 1'b0};
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_CALC;
                    end else begin
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                ST_CALC: begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DIGITS - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Result register trails entry into DONE by one cycle
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        p_out     <= '0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        out_valid <= 1'b1;
                        p_out     <= acc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth2_seq_mult.sv
// tb/tb_booth2_seq_mult.sv - self-checking bench for booth2_seq_mult
module tb_booth2_seq_mult;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] p_out;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    booth2_seq_mult dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p_out     (p_out),
        .busy      (busy)
    );

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
        longint pa;
        longint pb;
        pa = $signed(a);
        pb = $signed(b);
        return 32'(pa * pb);
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, n);
        end
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output bit zero_ok);
        lat = -1;
        zero_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (out_valid) begin
                lat = i;
                break;
            end
            if (p_out !== 32'h0) zero_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || p_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%0b busy=%0b p_out=%h, want 0 0 00000000", out_valid, busy, p_out);
        end
        sys_rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_latency();
        int lat;
        bit zok;
        out_ready = 1'b1;
        accept(16'd3, 16'd5);
        wait_result(lat, zok);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL latency: got %0d want 9", lat);
        end
        checks++;
        if (p_out !== 32'h0000000F) begin
            errors++;
            $display("FAIL prod_3x5: got %h want 0000000f", p_out);
        end
        checks++;
        if (!zok) begin
            errors++;
            $display("FAIL p_out_zero_while_invalid: got nonzero want 0");
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_3x5: out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta [5] = '{16'h8000, 16'h8000, 16'hFFF9, 16'h7FFF, 16'h0001};
        logic [15:0] tb [5] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'hFFFF};
        logic [31:0] te [5] = '{32'h40000000, 32'hC0008000, 32'h0, 32'h3FFF0001, 32'hFFFFFFFF};
        int lat;
        bit zok;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            accept(ta[i], tb[i]);
            wait_result(lat, zok);
            checks++;
            if (lat !== 9 || p_out !== te[i]) begin
                errors++;
                $display("FAIL directed_%0d: a=%h b=%h lat=%0d p_out=%h, want lat 9 p_out %h", i, ta[i], tb[i], lat, p_out, te[i]);
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_p;
        int lat;
        bit zok;
        out_ready = 1'b0;
        exp_p = ref_prod(16'h1234, 16'hABCD);
        accept(16'h1234, 16'hABCD);
        wait_result(lat, zok);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a_in = 16'($urandom);
            b_in = 16'($urandom);
            step();
            checks++;
            if (out_valid !== 1'b1 || p_out !== exp_p || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold_%0d: out_valid=%0b p_out=%h in_ready=%0b busy=%0b, want 1 %h 0 1", i, out_valid, p_out, in_ready, busy, exp_p);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || p_out !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: out_valid=%0b p_out=%h in_ready=%0b busy=%0b, want 0 0 1 0", out_valid, p_out, in_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] oa [3] = '{16'h0102, 16'hFF00, 16'h7A5C};
        logic [15:0] ob [3] = '{16'h8001, 16'h0033, 16'hC3C3};
        int acc_t [$];
        logic [31:0] expq [$];
        logic [31:0] e;
        int k;
        int got;
        bit will_acc;
        k = 0;
        got = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a_in = oa[0];
        b_in = ob[0];
        for (int cyc = 0; cyc < 60; cyc++) begin
            will_acc = in_valid && in_ready;
            step();
            if (will_acc) begin
                acc_t.push_back(cyc);
                expq.push_back(ref_prod(a_in, b_in));
                k++;
                if (k < 3) begin
                    a_in = oa[k];
                    b_in = ob[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid && expq.size() > 0) begin
                e = expq.pop_front();
                got++;
                checks++;
                if (p_out !== e) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: got %h want %h", got, p_out, e);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (acc_t.size() != 3 || got != 3) begin
            errors++;
            $display("FAIL b2b_count: accepts=%0d results=%0d want 3 3", acc_t.size(), got);
        end else begin
            checks++;
            if (acc_t[1] - acc_t[0] != 11 || acc_t[2] - acc_t[1] != 11) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d,%0d want 11,11", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        bit zok;
        bit seen;
        out_ready = 1'b1;
        accept(16'd100, 16'd100);
        for (int i = 0; i < 4; i++) step();
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || p_out !== 32'h0) begin
            errors++;
            $display("FAIL abort_immediate: out_valid=%0b busy=%0b p_out=%h want 0 0 0", out_valid, busy, p_out);
        end
        step();
        sys_rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_valid: out_valid pulsed=1 want 0");
        end
        accept(16'd2, 16'd3);
        wait_result(lat, zok);
        checks++;
        if (lat !== 9 || p_out !== 32'd6) begin
            errors++;
            $display("FAIL abort_next_op: lat=%0d p_out=%h want 9 00000006", lat, p_out);
        end
        step();
    endtask

    task automatic test_random();
        logic [15:0] corners [6] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001, 16'hAAAA};
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp_p;
        int lat;
        int stall;
        for (int n = 0; n < 1000; n++) begin
            a = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
            exp_p = ref_prod(a, b);
            in_valid = 1'b0;
            out_ready = 1'b0;
            for (int i = $urandom_range(0, 3); i > 0; i--) step();
            accept(a, b);
            lat = -1;
            for (int i = 1; i <= 20; i++) begin
                in_valid = 1'($urandom);
                a_in = 16'($urandom);
                b_in = 16'($urandom);
                step();
                if (out_valid) begin
                    lat = i;
                    break;
                end
            end
            stall = $urandom_range(0, 3);
            for (int i = 0; i < stall; i++) step();
            checks++;
            if (lat !== 9 || out_valid !== 1'b1 || p_out !== exp_p) begin
                errors++;
                $display("FAIL random_%0d: a=%h b=%h lat=%0d out_valid=%0b p_out=%h want lat 9 valid 1 p_out %h", n, a, b, lat, out_valid, p_out, exp_p);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
